// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and helpers for the BNN layer-handoff blocks.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } fm_ser_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/fm_word_select.sv
// fm_word_select: picks word idx out of a flat bit vector, zero-padding past its end.
module fm_word_select #(
    parameter int BITS   = 196,
    parameter int WORD_W = 8,
    parameter int WPC    = 25,
    parameter int WW     = 5
) (
    input  logic [BITS-1:0]   vec,
    input  logic [WW-1:0]     idx,
    output logic [WORD_W-1:0] word
);

    logic [WPC*WORD_W-1:0] padded;

    assign padded = (WPC*WORD_W)'(vec);
    assign word   = padded[int'(idx)*WORD_W +: WORD_W];

endmodule

// File: rtl/feature_map_serializer.sv
// feature_map_serializer: snapshots a binary IC-channel feature map on data_in_ready and
// streams it out channel by channel as WORD_W-bit words over valid/ready.
module feature_map_serializer
    import bnn_pkg::*;
#(
    parameter int IMG_SIZE = 14,
    parameter int IC       = 10,
    parameter int WORD_W   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  data_in_ready,
    input  logic [IMG_SIZE*IMG_SIZE-1:0]          img_in [0:IC-1],
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WORD_W-1:0]                     out_data,
    output logic                                  out_last_ch,
    output logic                                  out_last,
    output logic [(IC > 1 ? $clog2(IC) : 1)-1:0]  ch_idx,
    output logic                                  done
);

    localparam int BITS = IMG_SIZE * IMG_SIZE;
    localparam int WPC  = ceil_div(BITS, WORD_W);
    localparam int CW   = IC > 1 ? $clog2(IC) : 1;
    localparam int WW   = WPC > 1 ? $clog2(WPC) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(IC - 1);
    localparam logic [WW-1:0] LAST_W = WW'(WPC - 1);

    if (WORD_W < 1 || IC < 1 || IMG_SIZE < 1) begin : g_bad_params
        $error("feature_map_serializer: WORD_W, IC and IMG_SIZE must all be >= 1");
    end

    fm_ser_state_t   state;
    logic [BITS-1:0] snap [0:IC-1];
    logic [CW-1:0]   ch, nxt_ch;
    logic [WW-1:0]   word, nxt_word, sel_idx;
    logic            wrap, fin;
    logic [BITS-1:0] sel_vec;
    logic [WORD_W-1:0] sel_word;

    // Outputs are registered, so the selector looks one word ahead; in IDLE it reads
    // straight from img_in because the snapshot is loaded on the same edge.
    always_comb begin
        wrap     = word == LAST_W;
        fin      = wrap && ch == LAST_C;
        nxt_word = wrap ? '0 : word + 1'b1;
        nxt_ch   = wrap ? ch + 1'b1 : ch;
        sel_vec  = state == STREAM ? snap[int'(nxt_ch) < IC ? nxt_ch : '0] : img_in[0];
        sel_idx  = state == STREAM ? nxt_word : '0;
    end

    fm_word_select #(
        .BITS   (BITS),
        .WORD_W (WORD_W),
        .WPC    (WPC),
        .WW     (WW)
    ) u_sel (
        .vec  (sel_vec),
        .idx  (sel_idx),
        .word (sel_word)
    );

    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && data_in_ready)
            snap <= img_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            word        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last_ch <= 1'b0;
            out_last    <= 1'b0;
            ch_idx      <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (data_in_ready) begin
                        state       <= STREAM;
                        ch          <= '0;
                        word        <= '0;
                        out_valid   <= 1'b1;
                        out_data    <= sel_word;
                        out_last_ch <= WPC == 1;
                        out_last    <= WPC == 1 && IC == 1;
                        ch_idx      <= '0;
                    end
                end
                STREAM: begin
                    if (!data_in_ready || (out_ready && fin)) begin
                        state       <= data_in_ready ? DONE : IDLE;
                        done        <= data_in_ready;
                        ch          <= '0;
                        word        <= '0;
                        out_valid   <= 1'b0;
                        out_data    <= '0;
                        out_last_ch <= 1'b0;
                        out_last    <= 1'b0;
                        ch_idx      <= '0;
                    end else if (out_ready) begin
                        ch          <= nxt_ch;
                        word        <= nxt_word;
                        out_data    <= sel_word;
                        out_last_ch <= nxt_word == LAST_W;
                        out_last    <= nxt_word == LAST_W && nxt_ch == LAST_C;
                        ch_idx      <= nxt_ch;
                    end
                end
                DONE: begin
                    if (!data_in_ready) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_map_serializer.sv
// tb_feature_map_serializer: scoreboard bench; expected words are queued at capture time
// from a bench-side copy of the map and popped as the DUT hands words over.
module tb_feature_map_serializer;

    localparam int IMG_SIZE = 14;
    localparam int IC       = 10;
    localparam int WORD_W   = 8;
    localparam int BITS     = IMG_SIZE * IMG_SIZE;
    localparam int WPC      = 25;
    localparam int NW       = IC * WPC;

    logic             clk = 1'b0;
    logic             rst;
    logic             data_in_ready;
    logic [BITS-1:0]  img [0:IC-1];
    logic [BITS-1:0]  ref_img [0:IC-1];
    logic             out_valid;
    logic             out_ready;
    logic [WORD_W-1:0] out_data;
    logic             out_last_ch;
    logic             out_last;
    logic [3:0]       ch_idx;
    logic             done;

    logic [13:0] sb [$];
    int checks = 0;
    int failures = 0;

    feature_map_serializer #(
        .IMG_SIZE (IMG_SIZE),
        .IC       (IC),
        .WORD_W   (WORD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in_ready (data_in_ready),
        .img_in        (img),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last_ch   (out_last_ch),
        .out_last      (out_last),
        .ch_idx        (ch_idx),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] exp_word(input int c, input int w);
        logic [7:0] d;
        d = '0;
        for (int k = 0; k < WORD_W; k++)
            if (w * WORD_W + k < BITS) d[k] = ref_img[c][w * WORD_W + k];
        return {d, w == WPC - 1, w == WPC - 1 && c == IC - 1, 4'(c)};
    endfunction

    task automatic push_frame();
        for (int c = 0; c < IC; c++)
            for (int w = 0; w < WPC; w++) sb.push_back(exp_word(c, w));
    endtask

    task automatic set_pattern(input int kind);
        for (int c = 0; c < IC; c++)
            for (int i = 0; i < BITS; i++)
                img[c][i] = kind == 0 ? ((i + c) % 3 == 0) :
                            kind == 1 ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    // Enter from a negedge; drops data_in_ready one cycle, then raises it to capture img.
    task automatic start_frame();
        data_in_ready = 1'b0;
        @(negedge clk);
        check("idle_done", done, 0);
        ref_img = img;
        push_frame();
        data_in_ready = 1'b1;
        @(negedge clk);
        check("start_valid", out_valid, 1);
        check("start_ch", ch_idx, 0);
    endtask

    task automatic stream(input int n, input bit rnd);
        int got = 0;
        int cyc = 0;
        bit hold = 0;
        logic [13:0] prev = '0;
        logic [13:0] cur;
        logic [13:0] e;
        while (got < n) begin
            cur = {out_data, out_last_ch, out_last, ch_idx};
            if (hold) check("stall_stable", cur, prev);
            if (!rnd) check("contig_valid", out_valid, 1);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("word%0d", got), cur, e);
                end
                got++;
            end
            hold = out_valid && !out_ready;
            prev = cur;
            @(negedge clk);
            if (++cyc > 4000) begin
                check("timeout", got, n);
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic check_done();
        check("done_set", done, 1);
        check("done_no_valid", out_valid, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        data_in_ready = 1'b1;
        out_ready = 1'b1;
        set_pattern(0);
        repeat (3) begin
            @(negedge clk);
            check("rst_valid", out_valid, 0);
            check("rst_done", done, 0);
        end
        ref_img = img;
        push_frame();
        rst = 1'b0;
        @(negedge clk);
        check("first_valid", out_valid, 1);
        check("first_ch", ch_idx, 0);
        stream(NW, 0);
        check_done();

        set_pattern(1);
        start_frame();
        check("ones_w0", out_data, 8'hFF);
        stream(NW, 0);
        check_done();

        set_pattern(0);
        start_frame();
        stream(NW, 1);
        check_done();

        set_pattern(2);
        start_frame();
        stream(30, 0);
        data_in_ready = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        sb.delete();
        set_pattern(2);
        start_frame();
        stream(NW, 0);
        check_done();

        set_pattern(0);
        start_frame();
        set_pattern(2);
        stream(NW, 1);
        check_done();
        repeat (10) begin
            @(negedge clk);
            check("hold_done", done, 1);
            check("hold_no_valid", out_valid, 0);
        end
        start_frame();
        stream(NW, 0);
        check_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
